// File: rtl/dmem_stage.sv
// MEM-stage data memory: multi-cycle word access on an internal array.
// A request seen in IDLE stalls the pipeline for MEM_LAT cycles; the access
// completes in the following "done" cycle (load data on RD, or array write).
// Optional feature macro: DMEM_PERF_EN adds load_cnt / store_cnt counters.
module dmem_stage #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALU_out,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        stall,
    output logic        misalign
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] LatM1 = 4'(MEM_LAT - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wd_q, wd_d;
    logic            wr_q, wr_d;
    logic            misalign_q, misalign_d;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            done;
    logic            mem_we;

    // Address bits outside the word index only alias; they are intentionally dropped.
    logic            unused_addr;
    assign unused_addr = ^ALU_out[31:AW+2];

    assign req    = MemRead | MemWrite;
    assign done   = (state_q == StBusy) && (cnt_q == 4'd0);
    assign mem_we = done && wr_q;

    // Next-state logic and pipeline-facing outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        wr_d       = wr_q;
        misalign_d = misalign_q;
        stall      = 1'b0;
        RD         = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    stall   = 1'b1;
                    state_d = StBusy;
                    cnt_d   = LatM1;
                    idx_d   = ALU_out[AW+1:2];
                    wd_d    = WD;
                    // Read+write together is a write.
                    wr_d    = MemWrite;
                    if (ALU_out[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Done cycle: inputs still belong to this instruction, never re-sampled.
                    state_d = StIdle;
                    if (!wr_q) begin
                        RD = mem[idx_q];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset forces the pipeline free even if the request inputs are still high.
        if (!rst_n) begin
            stall = 1'b0;
            RD    = 32'd0;
        end
    end

    // Control and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wd_q       <= 32'd0;
            wr_q       <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
            wr_q       <= wr_d;
            misalign_q <= misalign_d;
        end
    end

    // Array write at the done edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wd_q;
        end
    end

    assign misalign = misalign_q;

`ifdef DMEM_PERF_EN
    logic [31:0] load_cnt_q, store_cnt_q;

    // Completed-access counters, wrapping naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= 32'd0;
            store_cnt_q <= 32'd0;
        end else if (done) begin
            if (wr_q) begin
                store_cnt_q <= store_cnt_q + 32'd1;
            end else begin
                load_cnt_q  <= load_cnt_q + 32'd1;
            end
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: instruction-level reference model,
// per-cycle comparison on the falling edge, plus literal pins.
module tb_dmem_stage;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned MEM_LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALU_out;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        stall;
    logic        misalign;
`ifdef DMEM_PERF_EN
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
`endif

    dmem_stage #(
        .DEPTH   (DEPTH),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ALU_out  (ALU_out),
        .WD       (WD),
        .RD       (RD),
        .stall    (stall),
        .misalign (misalign)
`ifdef DMEM_PERF_EN
        ,
        .load_cnt (load_cnt),
        .store_cnt(store_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_valid [DEPTH];
    bit          mdl_mis;
    int unsigned mdl_loads;
    int unsigned mdl_stores;

    // Expectations for the current cycle
    bit          chk_en;
    logic        exp_stall;
    logic [31:0] exp_rd;
    bit          exp_rd_known;
    logic        exp_mis;
    logic [31:0] exp_lc;
    logic [31:0] exp_sc;
    bit          lit_en;
    logic [31:0] lit_rd;
    logic        lit_mis;
    bit          lit_perf_en;
    logic [31:0] lit_lc;
    logic [31:0] lit_sc;

    int n_tests;
    int n_fail;

    // Compare process: the only writer of the counters.
    initial begin
        n_tests = 0;
        n_fail  = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_tests++;
                if (stall !== exp_stall) begin
                    n_fail++;
                    $display("FAIL stall: got %0b want %0b at %0t", stall, exp_stall, $time);
                end
                if (exp_rd_known) begin
                    n_tests++;
                    if (RD !== exp_rd) begin
                        n_fail++;
                        $display("FAIL rd: got %08h want %08h at %0t", RD, exp_rd, $time);
                    end
                end
                n_tests++;
                if (misalign !== exp_mis) begin
                    n_fail++;
                    $display("FAIL misalign: got %0b want %0b at %0t", misalign, exp_mis, $time);
                end
`ifdef DMEM_PERF_EN
                n_tests++;
                if (load_cnt !== exp_lc || store_cnt !== exp_sc) begin
                    n_fail++;
                    $display("FAIL perf: got %0d/%0d want %0d/%0d at %0t",
                             load_cnt, store_cnt, exp_lc, exp_sc, $time);
                end
`endif
            end
            if (lit_en) begin
                n_tests++;
                if (RD !== lit_rd || misalign !== lit_mis) begin
                    n_fail++;
                    $display("FAIL pin: got rd=%08h mis=%0b want rd=%08h mis=%0b at %0t",
                             RD, misalign, lit_rd, lit_mis, $time);
                end
            end
`ifdef DMEM_PERF_EN
            if (lit_perf_en) begin
                n_tests++;
                if (load_cnt !== lit_lc || store_cnt !== lit_sc) begin
                    n_fail++;
                    $display("FAIL perf_pin: got %0d/%0d want %0d/%0d at %0t",
                             load_cnt, store_cnt, lit_lc, lit_sc, $time);
                end
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lit_en      = 1'b0;
        lit_perf_en = 1'b0;
    endtask

    task automatic set_idle_exp();
        exp_stall    = 1'b0;
        exp_rd       = 32'd0;
        exp_rd_known = 1'b1;
        exp_mis      = mdl_mis;
        exp_lc       = mdl_loads;
        exp_sc       = mdl_stores;
    endtask

    task automatic do_reset();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALU_out  = 32'd0;
        WD       = 32'd0;
        rst_n    = 1'b0;
        mdl_mis    = 1'b0;
        mdl_loads  = 0;
        mdl_stores = 0;
        set_idle_exp();
        lit_en  = 1'b1;
        lit_rd  = 32'd0;
        lit_mis = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One pipeline instruction; holds its inputs until the access completes.
    task automatic instr(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit pin, input logic [31:0] pin_rd,
                         input logic pin_mis);
        int unsigned idx;
        bit          mis_now;
        idx      = (a / 4) % DEPTH;
        mis_now  = (a % 4) != 0;
        MemRead  = r;
        MemWrite = w;
        ALU_out  = a;
        WD       = d;
        set_idle_exp();
        if (!(r || w)) begin
            if (pin) begin
                lit_en  = 1'b1;
                lit_rd  = pin_rd;
                lit_mis = pin_mis;
            end
            step();
            return;
        end
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            exp_stall    = 1'b1;
            exp_rd       = 32'd0;
            exp_rd_known = 1'b1;
            exp_mis      = mdl_mis;
            step();
            mdl_mis = mdl_mis | mis_now;
        end
        exp_stall = 1'b0;
        exp_mis   = mdl_mis;
        if (w) begin
            exp_rd       = 32'd0;
            exp_rd_known = 1'b1;
        end else begin
            exp_rd       = mdl_mem[idx];
            exp_rd_known = mdl_valid[idx];
        end
        if (pin) begin
            lit_en  = 1'b1;
            lit_rd  = pin_rd;
            lit_mis = pin_mis;
        end
        step();
        if (w) begin
            mdl_mem[idx]   = d;
            mdl_valid[idx] = 1'b1;
            mdl_stores++;
        end else begin
            mdl_loads++;
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mdl_mem[i]   = 32'd0;
            mdl_valid[i] = 1'b0;
        end
        lit_en      = 1'b0;
        lit_perf_en = 1'b0;
        lit_lc      = 32'd0;
        lit_sc      = 32'd0;
        chk_en      = 1'b1;
        do_reset();

        // Store then load
        instr(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
        instr(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        // Idle cycles
        for (int i = 0; i < 5; i++) instr(1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 32'd0, 1'b0);
        // Address wrap
        instr(1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0, 32'd0, 1'b0);
        instr(1'b1, 1'b0, 32'h000, 32'd0, 1'b1, 32'h12345678, 1'b0);
        // Misaligned load
        instr(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, 32'd0, 1'b0);
        instr(1'b1, 1'b0, 32'h13, 32'd0, 1'b1, 32'hA5A5A5A5, 1'b1);
        instr(1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 32'd0, 1'b1);

        // Randomized instruction mix over a small aliased address window
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [1:0]  kind;
            kind = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 15) * 4) + ($urandom_range(0, 3) * 32'h400);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            case (kind)
                2'd0: instr(1'b0, 1'b0, a, $urandom, 1'b0, 32'd0, 1'b0);
                2'd1: instr(1'b1, 1'b0, a, $urandom, 1'b0, 32'd0, 1'b0);
                2'd2: instr(1'b0, 1'b1, a, $urandom, 1'b0, 32'd0, 1'b0);
                default: instr(1'b1, ($urandom_range(0, 1) == 1), a, $urandom,
                               1'b0, 32'd0, 1'b0);
            endcase
        end

        // Reset mid-access
        do_reset();
        instr(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'd0, 1'b0);
        MemRead  = 1'b0;
        MemWrite = 1'b1;
        ALU_out  = 32'h20;
        WD       = 32'hFFFFFFFF;
        set_idle_exp();
        exp_stall = 1'b1;
        step();
        // First BUSY cycle: pull reset with the store request still applied
        rst_n      = 1'b0;
        mdl_mis    = 1'b0;
        mdl_loads  = 0;
        mdl_stores = 0;
        set_idle_exp();
        lit_en  = 1'b1;
        lit_rd  = 32'd0;
        lit_mis = 1'b0;
        step();
        MemWrite = 1'b0;
        rst_n    = 1'b1;
        instr(1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0);
        instr(1'b1, 1'b0, 32'h20, 32'd0, 1'b1, 32'h0, 1'b0);

        // Access counters
        do_reset();
        instr(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 1'b0);
        instr(1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0);
        instr(1'b0, 1'b1, 32'h44, 32'h01020304, 1'b0, 32'd0, 1'b0);
        instr(1'b1, 1'b0, 32'h44, 32'd0, 1'b1, 32'h01020304, 1'b0);
        instr(1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0);
        instr(1'b1, 1'b1, 32'h48, 32'h0BADF00D, 1'b0, 32'd0, 1'b0);
        instr(1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0);
        instr(1'b1, 1'b0, 32'h48, 32'd0, 1'b1, 32'h0BADF00D, 1'b0);
        instr(1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        set_idle_exp();
        lit_perf_en = 1'b1;
        lit_lc      = 32'd3;
        lit_sc      = 32'd2;
        step();

        chk_en = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
